nukv_stream_serializer: RTL and testbench



---
 rtl/nukv_ser_pkg.sv | 18 +
 rtl/nukv_ser_slice_mux.sv | 24 ++
 rtl/nukv_stream_serializer.sv | 97 +++++++++
 tb/tb_nukv_stream_serializer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/nukv_ser_pkg.sv
`timescale 1ns/1ps
// nukv_ser_pkg
//   Shared definitions for the stream serializer: FSM state encoding and
//   the beat-count decode (a count of 0 stands for a completely full word).
package nukv_ser_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    // tcnt of 0 encodes a full word of `ratio` beats.
    function automatic int unsigned ser_cnt_to_lim(input int unsigned cnt,
                                                   input int unsigned ratio);
        return (cnt == 0) ? ratio : cnt;
    endfunction

endpackage

// File: rtl/nukv_ser_slice_mux.sv
`timescale 1ns/1ps
// nukv_ser_slice_mux
//   Combinational selector: returns slice `sel` (OUT_WIDTH bits) of a
//   RATIO-slice word. Slice k occupies bits [k*OUT_WIDTH +: OUT_WIDTH].
// Ports:
//   din   in  OUT_WIDTH*RATIO  packed word
//   sel   in  $clog2(RATIO)    slice index
//   dout  out OUT_WIDTH        selected slice
module nukv_ser_slice_mux #(
    parameter int OUT_WIDTH = 16,
    parameter int RATIO     = 4,
    parameter int SEL_BITS  = $clog2(RATIO)
) (
    input  logic [OUT_WIDTH*RATIO-1:0] din,
    input  logic [SEL_BITS-1:0]        sel,
    output logic [OUT_WIDTH-1:0]       dout
);

    logic [RATIO-1:0][OUT_WIDTH-1:0] slices;

    assign slices = din;
    assign dout   = slices[sel];

endmodule

// File: rtl/nukv_stream_serializer.sv
`timescale 1ns/1ps
// nukv_stream_serializer
//   Splits wide words from a first-word-fall-through FIFO into RATIO narrow
//   beats on a valid/ready master stream. Each word carries a beat count
//   (0 = full word). One beat per cycle, no bubble between words.
//
//   Optional build macro NUKV_SER_MSB_FIRST_EN: emit beats from index lim-1
//   down to 0 instead of 0 up to lim-1.
//
// Ports:
//   axis_clk, axis_rstn   clock, async active-low reset
//   s_axis_tdata/tcnt     input word and its valid beat count
//   s_axis_tvalid         FIFO not empty
//   s_axis_tready         word consumed this cycle (FIFO rd_en)
//   m_axis_tdata/tvalid/tlast/tready   narrow output stream
module nukv_stream_serializer
    import nukv_ser_pkg::*;
#(
    parameter int OUT_WIDTH = 16,
    parameter int RATIO     = 4,
    parameter int CNT_BITS  = $clog2(RATIO)
) (
    input  logic                       axis_clk,
    input  logic                       axis_rstn,
    input  logic [OUT_WIDTH*RATIO-1:0] s_axis_tdata,
    input  logic [CNT_BITS-1:0]        s_axis_tcnt,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [OUT_WIDTH-1:0]       m_axis_tdata,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready
);

    // lim can equal RATIO, so it needs one bit more than idx.
    localparam int LIM_BITS = CNT_BITS + 1;

    ser_state_t                 state;
    logic [OUT_WIDTH*RATIO-1:0] word_q;
    logic [CNT_BITS-1:0]        idx_q;
    logic [LIM_BITS-1:0]        lim_q;

    logic [LIM_BITS-1:0]        lim_next;
    logic [CNT_BITS-1:0]        idx_first;
    logic [CNT_BITS-1:0]        idx_step;
    logic                       at_last;
    logic                       load;
    logic                       beat_hs;

    assign lim_next = LIM_BITS'(ser_cnt_to_lim(32'(s_axis_tcnt), RATIO));

`ifdef NUKV_SER_MSB_FIRST_EN
    assign idx_first = CNT_BITS'(lim_next - LIM_BITS'(1));
    assign idx_step  = idx_q - CNT_BITS'(1);
    assign at_last   = (idx_q == '0);
`else
    assign idx_first = '0;
    assign idx_step  = idx_q + CNT_BITS'(1);
    assign at_last   = ({1'b0, idx_q} == (lim_q - LIM_BITS'(1)));
`endif

    assign m_axis_tvalid = (state == ST_SEND);
    assign m_axis_tlast  = m_axis_tvalid & at_last;
    assign beat_hs       = m_axis_tvalid & m_axis_tready;

    // No path from s_axis_tvalid: the FIFO may use this directly as rd_en.
    assign s_axis_tready = (state == ST_IDLE) | (m_axis_tready & m_axis_tlast);
    assign load          = s_axis_tready & s_axis_tvalid;

    nukv_ser_slice_mux #(
        .OUT_WIDTH (OUT_WIDTH),
        .RATIO     (RATIO)
    ) u_mux (
        .din  (word_q),
        .sel  (idx_q),
        .dout (m_axis_tdata)
    );

    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            state  <= ST_IDLE;
            word_q <= '0;
            idx_q  <= '0;
            lim_q  <= LIM_BITS'(RATIO);
        end else if (load) begin
            // Covers both IDLE pickup and chaining on the final beat.
            state  <= ST_SEND;
            word_q <= s_axis_tdata;
            lim_q  <= lim_next;
            idx_q  <= idx_first;
        end else if (beat_hs) begin
            if (at_last) state <= ST_IDLE;
            else         idx_q <= idx_step;
        end
    end

endmodule

// File: tb/tb_nukv_stream_serializer.sv
`timescale 1ns/1ps
module tb_nukv_stream_serializer;

    localparam int OW = 8;
    localparam int R  = 4;
    localparam int CB = 2;

    logic              axis_clk = 1'b0;
    logic              axis_rstn = 1'b0;
    logic [OW*R-1:0]   s_axis_tdata = '0;
    logic [CB-1:0]     s_axis_tcnt = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic [OW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready = 1'b1;

    nukv_stream_serializer #(.OUT_WIDTH(OW), .RATIO(R)) dut (
        .axis_clk      (axis_clk),
        .axis_rstn     (axis_rstn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tcnt   (s_axis_tcnt),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
    );

    always #5 axis_clk = ~axis_clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source words {tcnt, tdata} and expected beats {last, data}.
    logic [33:0] src_q[$];
    logic [8:0]  exp_q[$];

    int       rdy_mode = 0;   // 0: always ready, 1: pattern 1,0,0
    int       rdy_cnt  = 0;
    int       beats_seen = 0;
    logic     prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic     prev_last = 1'b0;
    logic     streaming = 1'b0;

    task automatic push_word(input logic [31:0] data, input logic [1:0] cnt);
        int lim;
        logic [31:0] d;
        d = data;
        lim = (cnt == 2'd0) ? R : int'(cnt);
        src_q.push_back({cnt, data});
`ifdef NUKV_SER_MSB_FIRST_EN
        for (int k = lim - 1; k >= 0; k--)
            exp_q.push_back({(k == 0), d[k*OW +: OW]});
`else
        for (int k = 0; k < lim; k++)
            exp_q.push_back({(k == lim - 1), d[k*OW +: OW]});
`endif
    endtask

    // Drive on the falling edge, then sample 1ns later; values are stable
    // until the next rising edge, so what is seen here is the handshake.
    always @(negedge axis_clk) begin
        logic [8:0] e;
        rdy_cnt++;
        m_axis_tready = (rdy_mode == 0) ? 1'b1 : (rdy_cnt % 3 == 0);
        if (src_q.size() > 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tcnt   = src_q[0][33:32];
            s_axis_tdata  = src_q[0][31:0];
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tcnt   = '0;
            s_axis_tdata  = '0;
        end
        #1;
        if (!axis_rstn) begin
            prev_stall = 1'b0;
            streaming  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(m_axis_tvalid), 32'd1);
                chk("hold_data",  32'(m_axis_tdata), 32'(prev_data));
                chk("hold_last",  32'(m_axis_tlast), 32'(prev_last));
            end
            if (exp_q.size() == 0)
                chk("spurious_valid", 32'(m_axis_tvalid), 32'd0);
            if (streaming && rdy_mode == 0 && exp_q.size() > 0)
                chk("no_bubble", 32'(m_axis_tvalid), 32'd1);
            if (m_axis_tvalid)
                chk("s_tready", 32'(s_axis_tready), 32'(m_axis_tready & m_axis_tlast));
            if (m_axis_tvalid && m_axis_tready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("beat_data", 32'(m_axis_tdata), 32'(e[7:0]));
                chk("beat_last", 32'(m_axis_tlast), 32'(e[8]));
                beats_seen++;
                streaming = (exp_q.size() > 0);
            end
            prev_stall = m_axis_tvalid & ~m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (s_axis_tvalid && s_axis_tready && src_q.size() > 0)
                void'(src_q.pop_front());
        end
    end

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            @(negedge axis_clk); #2;
            if (exp_q.size() == 0 && src_q.size() == 0) break;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge axis_clk);
    endtask

    initial begin
        int base;
        int vcount;
        // Reset held for 3 cycles
        axis_rstn = 1'b0;
        repeat (3) @(negedge axis_clk);
        #1;
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_tlast",  32'(m_axis_tlast),  32'd0);
        chk("rst_tdata",  32'(m_axis_tdata),  32'd0);
        chk("rst_sready", 32'(s_axis_tready), 32'd1);
        @(negedge axis_clk);
        axis_rstn = 1'b1;
        @(negedge axis_clk);

        // Single full word
        rdy_mode = 0;
        push_word(32'hDDCCBBAA, 2'd0);
        drain();

        // Partial words back-to-back
        push_word(32'h44332211, 2'd2);
        push_word(32'h88776655, 2'd3);
        drain();

        // Backpressure
        rdy_mode = 1;
        push_word(32'hDDCCBBAA, 2'd0);
        push_word(32'h13572468, 2'd3);
        push_word(32'hCAFEF00D, 2'd1);
        drain();
        rdy_mode = 0;

        // Back-to-back single-beat words
        push_word(32'h000000A1, 2'd1);
        push_word(32'h000000B2, 2'd1);
        push_word(32'h000000C3, 2'd1);
        push_word(32'h0000D400, 2'd2);
        drain();

        // Mid-word reset after the second beat
        base = beats_seen;
        push_word(32'hDDCCBBAA, 2'd0);
        for (int i = 0; i < 50; i++) begin
            @(negedge axis_clk); #2;
            if (beats_seen >= base + 2) break;
        end
        chk("midrst_reached", 32'(beats_seen - base), 32'd2);
        @(negedge axis_clk);
        axis_rstn = 1'b0;
        exp_q.delete();
        src_q.delete();
        #1;
        chk("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("midrst_tlast",  32'(m_axis_tlast),  32'd0);
        chk("midrst_sready", 32'(s_axis_tready), 32'd1);
        repeat (2) @(negedge axis_clk);
        axis_rstn = 1'b1;
        vcount = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge axis_clk); #2;
            if (m_axis_tvalid) vcount++;
        end
        chk("midrst_no_beats", 32'(vcount), 32'd0);

        // Traffic still works after the reset
        push_word(32'h0F1E2D3C, 2'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
